sm_controller: RTL
==================

Name: sm_controller

Overview:
- Instruction-sequencing FSM for the 16-bit register/ALU datapath: latches a 16-bit instruction and decodes it.
- Drives every datapath control input (register file select/write, A/B/C/status load enables, operand muxes, shift, ALU op, writeback mux) over a multi-cycle sequence.
- Sits between instruction fetch (or the bench) and the datapath; handshakes completion via w.

Parameters:
- ILLEGAL_HALT, 1, 1: undefined opcode enters HALT until reset; 0: undefined opcode flags err for one cycle and returns to WAIT.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in  input  16  instruction word
- load  input  1  capture in into IR (honoured only while w=1)
- s  input  1  start execution of IR (honoured only in WAIT)
- w  output  1  1 = idle in WAIT, ready for new instruction
- err  output  1  undefined-instruction flag
- readnum, writenum  output  3 each  register file read/write index
- vsel  output  2  writeback select: 00 C, 01 PC, 10 sximm8, 11 mdata
- loada, loadb, loadc, loads, write  output  1 each  datapath enables
- asel, bsel  output  1 each  A=0 select / B=sximm5 select
- shift, ALUop  output  2 each  shifter op, ALU op
- sximm8, sximm5  output  16 each  sign-extended IR[7:0], IR[4:0]

Behaviour:
- IR fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
- Legal instructions:
  - 110/10 MOV Rn,#imm8
  - 110/00 MOV Rd,Rm{,sh}
  - 101/00 ADD
  - 101/01 CMP
  - 101/10 AND
  - 101/11 MVN
  - All other opcode/op combinations are illegal.
- Reset (async) state: state=WAIT, IR=0, w=1, err=0, all enables 0, readnum/writenum/vsel/shift/ALUop=0, asel=bsel=0.
- Outputs are Moore, decoded from state and IR. Enables are asserted only in the states listed below; every unlisted enable is 0. sximm8/sximm5 are combinational from IR in every state.
- IR: on the clk edge where load=1 and w=1, IR<=in. load while w=0 is ignored.
- States: WAIT, DECODE, GET_A, GET_B, ALU, WR_REG, WR_IMM, HALT.
- WAIT: w=1. s=1 -> DECODE. If s and load are asserted together, the newly loaded IR is the one executed.
- DECODE: w=0, no enables asserted.
  - MOV imm -> WR_IMM
  - MOV reg, MVN -> GET_B
  - ADD/CMP/AND -> GET_A
  - illegal -> HALT (ILLEGAL_HALT=1) or WAIT with err=1 for that one cycle (ILLEGAL_HALT=0)
- GET_A: readnum=Rn, loada=1 -> GET_B.
- GET_B: readnum=Rm, loadb=1 -> ALU.
- ALU: shift=sh, bsel=0, ALUop=op; ALUop=00 for MOV reg.
  - asel=1 for MOV reg/MVN, else 0.
  - CMP: loads=1, loadc=0 -> WAIT.
  - Others: loadc=1 -> WR_REG.
- WR_REG: vsel=00, writenum=Rd, write=1 -> WAIT.
- WR_IMM: vsel=10, writenum=Rn, write=1 -> WAIT.
- HALT: w=0, err=1, no enables; left only via reset.
- shift=00 in all states except ALU.
- Latency, in cycles with w=0 after the accepting edge:
  - MOV imm: 2
  - MOV reg, MVN, CMP: 4
  - ADD, AND: 5
- s held high continuously: a new execution starts in the cycle after return to WAIT (one WAIT cycle minimum, w=1 for that cycle).
- Reset mid-instruction: immediate return to reset values, w=1, no further writes. A register write in progress is only guaranteed if its clk edge precedes reset assertion.

Optional Feature:
- Macro SM_CTRL_PERF_CNT_EN adds output instr_count[15:0].
- With the macro: instr_count resets to 0 and increments by 1 on each transition into WAIT from WR_REG, WR_IMM or ALU(CMP). It wraps 0xFFFF->0x0000. Illegal instructions are not counted.
- Without the macro: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then load 0xD007 and pulse s -> WR_IMM cycle shows write=1, vsel=10, writenum=0, sximm8=0x0007. w=0 for exactly 2 cycles, then 1.
- Load 0xD102 then 0xA148 (ADD R2,R1,R0,LSL#1) on integrated datapath (R0=7 from first test) -> 5 busy cycles. Sequence GET_A(readnum=1), GET_B(readnum=0), ALU(shift=01), WR_REG(writenum=2). R2=0x0010.
- 0xA800 (CMP R0,R0) -> loads=1 in ALU, write never asserted, Z=1, 4 busy cycles.
- 0xE000 with ILLEGAL_HALT=1 -> err=1 and w=0 permanently, s ignored; reset clears to w=1, err=0. With ILLEGAL_HALT=0 -> single-cycle err pulse, w=1 next cycle.
- load=1 with in=0xD0FF during ADD execution -> IR unchanged, ADD completes normally. sximm8=0xFFFF only after reloading 0xD0FF while idle.
- Assert reset asynchronously during GET_A of 0xA148 -> outputs reach reset values before next clk edge. No write occurs; R2 unchanged.

Source files
------------

// File: rtl/sm_controller.sv
// sm_controller: instruction-sequencing FSM for the 16-bit register/ALU datapath.
// Latches an instruction word into IR and walks the datapath control signals
// through a multi-cycle sequence. w=1 marks idle in WAIT, ready for a new instruction.
// Optional feature: define SM_CTRL_PERF_CNT_EN to add instr_count[15:0], a
// wrapping count of completed legal instructions.
module sm_controller #(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic        err,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        write,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
`ifdef SM_CTRL_PERF_CNT_EN
    ,
    output logic [15:0] instr_count
`endif
);

    typedef enum logic [2:0] {
        S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_ALU, S_WR_REG, S_WR_IMM, S_HALT
    } state_t;

    typedef struct packed {
        logic       w;
        logic       err;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic [1:0] vsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       write;
        logic       asel;
        logic       bsel;
        logic [1:0] shift;
        logic [1:0] alu_op;
    } ctrl_t;

    state_t      state, state_nxt;
    logic [15:0] ir, ir_nxt;
    ctrl_t       ctrl;

    // Instruction class decode on {opcode, op} = IR[15:11]
    function automatic logic is_mov_imm(input logic [15:0] i);
        return i[15:11] == 5'b11010;
    endfunction

    function automatic logic is_mov_reg(input logic [15:0] i);
        return i[15:11] == 5'b11000;
    endfunction

    function automatic logic is_alu(input logic [15:0] i);
        return i[15:13] == 3'b101;
    endfunction

    function automatic logic is_cmp(input logic [15:0] i);
        return i[15:11] == 5'b10101;
    endfunction

    function automatic logic is_mvn(input logic [15:0] i);
        return i[15:11] == 5'b10111;
    endfunction

    // Moore output decode for a given state and IR contents
    function automatic ctrl_t decode(input state_t st, input logic [15:0] i);
        ctrl_t o;
        o = '0;
        case (st)
            S_WAIT:   o.w = 1'b1;
            S_DECODE: o.err = !ILLEGAL_HALT && !(is_mov_imm(i) || is_mov_reg(i) || is_alu(i));
            S_GET_A: begin
                o.readnum = i[10:8];
                o.loada   = 1'b1;
            end
            S_GET_B: begin
                o.readnum = i[2:0];
                o.loadb   = 1'b1;
            end
            S_ALU: begin
                o.shift  = i[4:3];
                o.alu_op = is_mov_reg(i) ? 2'b00 : i[12:11];
                o.asel   = is_mov_reg(i) || is_mvn(i);
                o.loads  = is_cmp(i);
                o.loadc  = !is_cmp(i);
            end
            S_WR_REG: begin
                o.vsel     = 2'b00;
                o.writenum = i[7:5];
                o.write    = 1'b1;
            end
            S_WR_IMM: begin
                o.vsel     = 2'b10;
                o.writenum = i[10:8];
                o.write    = 1'b1;
            end
            S_HALT:   o.err = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    // Next-state and IR capture; load is honoured only in WAIT (the only w=1 state)
    always_comb begin
        state_nxt = state;
        ir_nxt    = ir;
        case (state)
            S_WAIT: begin
                if (load) ir_nxt = in;
                if (s) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (is_mov_imm(ir))                   state_nxt = S_WR_IMM;
                else if (is_mov_reg(ir) || is_mvn(ir)) state_nxt = S_GET_B;
                else if (is_alu(ir))                  state_nxt = S_GET_A;
                else if (ILLEGAL_HALT)                state_nxt = S_HALT;
                else                                  state_nxt = S_WAIT;
            end
            S_GET_A:  state_nxt = S_GET_B;
            S_GET_B:  state_nxt = S_ALU;
            S_ALU:    state_nxt = is_cmp(ir) ? S_WAIT : S_WR_REG;
            S_WR_REG: state_nxt = S_WAIT;
            S_WR_IMM: state_nxt = S_WAIT;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_WAIT;
        endcase
    end

    // State, IR and registered outputs; outputs are decoded from the next
    // state/IR so they always equal the Moore decode of the current state/IR
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_WAIT;
            ir    <= '0;
            ctrl  <= decode(S_WAIT, 16'h0000);
        end else begin
            state <= state_nxt;
            ir    <= ir_nxt;
            ctrl  <= decode(state_nxt, ir_nxt);
        end
    end

`ifdef SM_CTRL_PERF_CNT_EN
    // Count completions: return to WAIT from a write state or from CMP's ALU state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_count <= '0;
        end else if (state_nxt == S_WAIT &&
                     (state == S_WR_REG || state == S_WR_IMM || state == S_ALU)) begin
            instr_count <= instr_count + 16'd1;
        end
    end
`endif

    assign w        = ctrl.w;
    assign err      = ctrl.err;
    assign readnum  = ctrl.readnum;
    assign writenum = ctrl.writenum;
    assign vsel     = ctrl.vsel;
    assign loada    = ctrl.loada;
    assign loadb    = ctrl.loadb;
    assign loadc    = ctrl.loadc;
    assign loads    = ctrl.loads;
    assign write    = ctrl.write;
    assign asel     = ctrl.asel;
    assign bsel     = ctrl.bsel;
    assign shift    = ctrl.shift;
    assign ALUop    = ctrl.alu_op;
    assign sximm8   = {{8{ir[7]}}, ir[7:0]};
    assign sximm5   = {{11{ir[4]}}, ir[4:0]};

endmodule
